// File: rtl/cpu_io_port.sv
// cpu_io_port: I/O adapter placed beside the single-cycle core.
//   Output side: core words pushed on OutWe go into a first-word-fall-through
//   FIFO that drains to an external sink over OutValid/OutReady.
//   Input side: a one-entry holding register takes words from an external
//   source over InValid/InReady and holds them on CPUIn until InAck.
// Optional feature (macro CPU_IO_DEDUP_EN): drop pushes whose CPUOut equals
//   the last word actually pushed since reset. Undefined by default.
module cpu_io_port #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [WIDTH-1:0] CPUOut,
    input  logic             OutWe,
    output logic [WIDTH-1:0] OutData,
    output logic             OutValid,
    input  logic             OutReady,
    output logic             OutFull,
    output logic             Overflow,
    input  logic [WIDTH-1:0] InData,
    input  logic             InValid,
    output logic             InReady,
    output logic [WIDTH-1:0] CPUIn,
    input  logic             InAck
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CNT_W-1:0] count;
    logic             overflow_q;
    logic             in_full;
    logic [WIDTH-1:0] cpu_in_q;

    logic             fifo_valid;
    logic             fifo_full;
    logic             pop;
    logic             push;
    logic             drop;
    logic             dup;

    assign fifo_valid = (count != '0);
    assign fifo_full  = (count == FULL_CNT);
    assign pop        = fifo_valid & OutReady;

`ifdef CPU_IO_DEDUP_EN
    logic [WIDTH-1:0] last_word;
    logic             last_valid;

    assign dup = last_valid & (CPUOut == last_word);

    // Remember the last word that actually entered the FIFO
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            last_word  <= '0;
            last_valid <= 1'b0;
        end else if (push) begin
            last_word  <= CPUOut;
            last_valid <= 1'b1;
        end
    end
`else
    assign dup = 1'b0;
`endif

    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign push = OutWe & ~dup & (~fifo_full | pop);
    assign drop = OutWe & ~dup & fifo_full & ~pop;

    // Storage array; contents need no reset because OutData is masked when empty
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= CPUOut;
        end
    end

    // Pointer, occupancy and sticky overflow tracking
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Input holding register; an ack while full blocks a same-cycle offer
    // because InReady is low, so the two branches never collide
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            in_full  <= 1'b0;
            cpu_in_q <= '0;
        end else if (InValid && !in_full) begin
            in_full  <= 1'b1;
            cpu_in_q <= InData;
        end else if (InAck && in_full) begin
            in_full  <= 1'b0;
        end
    end

    assign OutValid = fifo_valid;
    assign OutFull  = fifo_full;
    assign OutData  = fifo_valid ? mem[rd_ptr] : '0;
    assign Overflow = overflow_q;
    assign InReady  = ~in_full;
    assign CPUIn    = cpu_in_q;

endmodule
